// File: rtl/la_deglitch.sv
// Glitch filter and edge detector for a single-bit level. An optional resync
// chain feeds a counter FSM; z changes only after DEPTH consecutive new samples.
module la_deglitch #(
  parameter              PROP     = "DEFAULT",
  parameter int          SYNC     = 2,
  parameter int          DEPTH    = 4,
  parameter logic        RESETVAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic en,
  output logic z,
  output logic zrise,
  output logic zfall,
  output logic glitch,
  output logic busy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          s;

  // The resync chain shifts every cycle, independent of en.
  generate
    if (SYNC == 0) begin : g_nosync
      assign s = a;
    end else begin : g_sync
      logic [SYNC-1:0] sync_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          sync_q <= {SYNC{RESETVAL}};
        end else begin
          sync_q[0] <= a;
          for (int i = 1; i < SYNC; i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end
      assign s = sync_q[SYNC-1];
    end
  endgenerate

  assign busy = (state == ST_PENDING);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_STABLE;
      cnt    <= '0;
      z      <= RESETVAL;
      zrise  <= 1'b0;
      zfall  <= 1'b0;
      glitch <= 1'b0;
    end else begin
      zrise  <= 1'b0;
      zfall  <= 1'b0;
      glitch <= 1'b0;
      if (en) begin
        case (state)
          ST_STABLE: begin
            if (s != z) begin
              if (DEPTH == 1) begin
                z     <= s;
                zrise <= s;
                zfall <= ~s;
              end else begin
                state <= ST_PENDING;
                cnt   <= CW'(1);
              end
            end
          end
          ST_PENDING: begin
            if (s == z) begin
              state  <= ST_STABLE;
              cnt    <= '0;
              glitch <= 1'b1;
            end else if (cnt == CNT_LAST) begin
              z     <= s;
              zrise <= s;
              zfall <= ~s;
              state <= ST_STABLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: begin
            state <= ST_STABLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_la_deglitch.sv
// Bench for la_deglitch: three parameterisations checked every cycle against
// a run-length reference model, plus directed scenario checks.
module tb_la_deglitch;

  localparam int NI = 3;
  localparam int P_SYNC [NI] = '{2, 0, 1};
  localparam int P_DEPTH[NI] = '{4, 1, 3};
  localparam int P_RV   [NI] = '{1, 1, 0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic a_v[NI], en_v[NI], rst_v[NI];
  logic z_o[NI], zr_o[NI], zf_o[NI], gl_o[NI], bz_o[NI];

  la_deglitch #(.PROP("DEFAULT"), .SYNC(2), .DEPTH(4), .RESETVAL(1'b1)) u0 (
    .clk(clk), .rst(rst_v[0]), .a(a_v[0]), .en(en_v[0]),
    .z(z_o[0]), .zrise(zr_o[0]), .zfall(zf_o[0]), .glitch(gl_o[0]), .busy(bz_o[0]));
  la_deglitch #(.PROP("DEFAULT"), .SYNC(0), .DEPTH(1), .RESETVAL(1'b1)) u1 (
    .clk(clk), .rst(rst_v[1]), .a(a_v[1]), .en(en_v[1]),
    .z(z_o[1]), .zrise(zr_o[1]), .zfall(zf_o[1]), .glitch(gl_o[1]), .busy(bz_o[1]));
  la_deglitch #(.PROP("DEFAULT"), .SYNC(1), .DEPTH(3), .RESETVAL(1'b0)) u2 (
    .clk(clk), .rst(rst_v[2]), .a(a_v[2]), .en(en_v[2]),
    .z(z_o[2]), .zrise(zr_o[2]), .zfall(zf_o[2]), .glitch(gl_o[2]), .busy(bz_o[2]));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the sampled level is a delayed by SYNC cycles; z flips
  // once the run of samples differing from z reaches DEPTH.
  int m_sync[NI][4];
  int m_z[NI], m_run[NI], m_rise[NI], m_fall[NI], m_gl[NI];
  int c_rise[NI], c_fall[NI], c_gl[NI], c_busy[NI];

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int k);
    int s;
    if (rst_v[k]) begin
      for (int j = 0; j < 4; j++) m_sync[k][j] = P_RV[k];
      m_z[k] = P_RV[k]; m_run[k] = 0;
      m_rise[k] = 0; m_fall[k] = 0; m_gl[k] = 0;
    end else begin
      s = (P_SYNC[k] == 0) ? int'(a_v[k]) : m_sync[k][P_SYNC[k]-1];
      for (int j = 3; j > 0; j--) m_sync[k][j] = m_sync[k][j-1];
      m_sync[k][0] = int'(a_v[k]);
      m_rise[k] = 0; m_fall[k] = 0; m_gl[k] = 0;
      if (en_v[k]) begin
        if (s != m_z[k]) begin
          m_run[k]++;
          if (m_run[k] == P_DEPTH[k]) begin
            m_z[k] = s; m_rise[k] = s; m_fall[k] = 1 - s; m_run[k] = 0;
          end
        end else begin
          if (m_run[k] > 0) m_gl[k] = 1;
          m_run[k] = 0;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    for (int k = 0; k < NI; k++) model_step(k);
    #1;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("u%0d.z", k),      z_o[k],  logic'(m_z[k]));
      chk($sformatf("u%0d.zrise", k),  zr_o[k], logic'(m_rise[k]));
      chk($sformatf("u%0d.zfall", k),  zf_o[k], logic'(m_fall[k]));
      chk($sformatf("u%0d.glitch", k), gl_o[k], logic'(m_gl[k]));
      chk($sformatf("u%0d.busy", k),   bz_o[k], logic'(m_run[k] > 0));
      chk($sformatf("u%0d.onepulse", k), logic'((zr_o[k] + zf_o[k] + gl_o[k]) <= 2'd1), 1'b1);
      c_rise[k] += int'(zr_o[k]); c_fall[k] += int'(zf_o[k]);
      c_gl[k]   += int'(gl_o[k]); c_busy[k] += int'(bz_o[k]);
    end
  endtask

  task automatic set_all(input logic a, input logic en, input logic rst);
    for (int k = 0; k < NI; k++) begin
      a_v[k] = a; en_v[k] = en; rst_v[k] = rst;
    end
  endtask

  task automatic clr_counts();
    for (int k = 0; k < NI; k++) begin
      c_rise[k] = 0; c_fall[k] = 0; c_gl[k] = 0; c_busy[k] = 0;
    end
  endtask

  task automatic do_reset(input logic a, input int n);
    set_all(a, 1'b1, 1'b1);
    repeat (n) step();
    rst_v[0] = 1'b0; rst_v[1] = 1'b0; rst_v[2] = 1'b0;
    clr_counts();
  endtask

  int hold[NI];
  int fall_edge;

  initial begin
    set_all(1'b1, 1'b1, 1'b1);
    clr_counts();

    // Reset value, then quiet a=1 after release.
    repeat (3) begin
      step();
      chk("rst.z", z_o[0], 1'b1);
      chk("rst.busy", bz_o[0], 1'b0);
    end
    set_all(1'b1, 1'b1, 1'b0);
    clr_counts();
    repeat (4) step();
    chk("idle.z", z_o[0], 1'b1);
    chk("idle.pulses", logic'(c_rise[0] + c_fall[0] + c_gl[0] + c_busy[0] == 0), 1'b1);

    // Clean falling transition on u0: busy from E3, z falls at E6.
    do_reset(1'b1, 2);
    a_v[0] = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step();
      if (e == 2) chk("fall.busy_e2", bz_o[0], 1'b0);
      if (e == 3) chk("fall.busy_e3", bz_o[0], 1'b1);
      if (e == 5) chk("fall.z_e5", z_o[0], 1'b1);
      if (e == 6) begin
        chk("fall.z_e6", z_o[0], 1'b0);
        chk("fall.zfall_e6", zf_o[0], 1'b1);
      end
    end
    chk("fall.zfall_once", logic'(c_fall[0] == 1), 1'b1);
    chk("fall.no_rise_glitch", logic'(c_rise[0] + c_gl[0] == 0), 1'b1);

    // Glitch rejection: two low cycles.
    do_reset(1'b1, 2);
    set_all(1'b0, 1'b1, 1'b0);
    repeat (2) step();
    set_all(1'b1, 1'b1, 1'b0);
    repeat (8) step();
    chk("gl.busy2", logic'(c_busy[0] == 2), 1'b1);
    chk("gl.glitch1", logic'(c_gl[0] == 1), 1'b1);
    chk("gl.z", z_o[0], 1'b1);
    chk("gl.nofall", logic'(c_fall[0] == 0), 1'b1);

    // Enable freeze: en low for edges 5..9, z falls at edge 11.
    do_reset(1'b1, 2);
    set_all(1'b0, 1'b1, 1'b0);
    repeat (4) step();
    set_all(1'b0, 1'b0, 1'b0);
    repeat (5) begin
      step();
      chk("en.frozen_busy", bz_o[0], 1'b1);
      chk("en.frozen_z", z_o[0], 1'b1);
    end
    set_all(1'b0, 1'b1, 1'b0);
    step();
    chk("en.z_e10", z_o[0], 1'b1);
    step();
    chk("en.z_e11", z_o[0], 1'b0);
    chk("en.zfall_e11", zf_o[0], 1'b1);
    repeat (3) step();
    chk("en.zfall_once", logic'(c_fall[0] == 1), 1'b1);

    // Reset mid-PENDING at E5, then z falls 6 edges after release.
    do_reset(1'b1, 2);
    set_all(1'b0, 1'b1, 1'b0);
    repeat (4) step();
    set_all(1'b0, 1'b1, 1'b1);
    step();
    chk("mid.z", z_o[0], 1'b1);
    chk("mid.busy", bz_o[0], 1'b0);
    chk("mid.nopulse", logic'(c_fall[0] + c_gl[0] == 0), 1'b1);
    set_all(1'b0, 1'b1, 1'b0);
    fall_edge = 0;
    for (int e = 1; e <= 20 && fall_edge == 0; e++) begin
      step();
      if (z_o[0] === 1'b0) fall_edge = e;
    end
    chk("mid.latency6", logic'(fall_edge == 6), 1'b1);

    // SYNC=0, DEPTH=1 on u1: z follows a toggling every cycle.
    do_reset(1'b1, 2);
    for (int i = 0; i < 10; i++) begin
      a_v[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
      step();
      chk("b.z_follows", z_o[1], a_v[1]);
    end
    chk("b.rise5", logic'(c_rise[1] == 5), 1'b1);
    chk("b.fall5", logic'(c_fall[1] == 5), 1'b1);
    chk("b.noglitch_busy", logic'(c_gl[1] + c_busy[1] == 0), 1'b1);

    // Randomized run-length stimulus, independent per instance.
    for (int k = 0; k < NI; k++) hold[k] = 0;
    for (int c = 0; c < 2000; c++) begin
      for (int k = 0; k < NI; k++) begin
        if (hold[k] == 0) begin
          a_v[k]  = logic'($urandom_range(0, 1));
          hold[k] = $urandom_range(1, 7);
        end
        hold[k]--;
        en_v[k]  = ($urandom_range(0, 9) != 0);
        rst_v[k] = ($urandom_range(0, 249) == 0);
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
